// File: rtl/settings_menu_ctrl.sv
// Settings-menu controller: samples buttons once per frame, produces press/auto-repeat
// events and routes them to the focused menu component or to the game.
module settings_menu_ctrl #(
  parameter int unsigned REPEAT_DELAY = 8,
  parameter int unsigned REPEAT_RATE  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] buttons,
  input  logic       frame_tick,
  output logic       menu_open,
  output logic [1:0] focus,
  output logic       colors_en,
  output logic [7:0] colors_btn,
  output logic       sound_en,
  output logic [7:0] sound_btn,
  output logic [7:0] game_btn,
  output logic       menu_exit
);

  typedef enum logic {CLOSED, OPEN} state_e;
  typedef enum logic [1:0] {F_COLORS = 2'b00, F_SOUND = 2'b01, F_EXIT = 2'b10} focus_e;

  localparam logic [7:0] DELAY_C  = 8'(REPEAT_DELAY);
  localparam logic [7:0] RELOAD_C = 8'(REPEAT_DELAY - REPEAT_RATE);

  state_e     state_q, state_d;
  focus_e     focus_q, focus_d;
  logic [7:0] smp_q, smp_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] hold_inc;
  logic [3:0] rep;
  logic [7:0] ev;
  logic       colors_en_q, colors_en_d, sound_en_q, sound_en_d, menu_exit_q, menu_exit_d;
  logic [7:0] colors_btn_q, colors_btn_d, sound_btn_q, sound_btn_d, game_btn_q, game_btn_d;

  // Event vector: new presses plus direction auto-repeat; the counter reloads so it never wraps.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    hold_d   = hold_q;
    rep      = 4'h0;
    hold_inc = hold_q + 8'd1;
    smp_d    = smp_q;
    if (frame_tick) begin
      smp_d = buttons;
      if (buttons[3:0] != 4'h0 && buttons[3:0] == smp_q[3:0]) begin
        if (hold_inc == DELAY_C) begin
          rep    = buttons[3:0];
          hold_d = RELOAD_C;
        end else begin
          hold_d = hold_inc;
        end
      end else begin
        hold_d = 8'd0;
      end
    end
    ev = (buttons & ~smp_q) | {4'h0, rep};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= CLOSED;
      focus_q      <= F_COLORS;
      smp_q        <= 8'h00;
      hold_q       <= 8'd0;
      colors_en_q  <= 1'b0;
      colors_btn_q <= 8'h00;
      sound_en_q   <= 1'b0;
      sound_btn_q  <= 8'h00;
      game_btn_q   <= 8'h00;
      menu_exit_q  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      focus_q      <= focus_d;
      smp_q        <= smp_d;
      hold_q       <= hold_d;
      colors_en_q  <= colors_en_d;
      colors_btn_q <= colors_btn_d;
      sound_en_q   <= sound_en_d;
      sound_btn_q  <= sound_btn_d;
      game_btn_q   <= game_btn_d;
      menu_exit_q  <= menu_exit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    focus_d = focus_q;
    if (frame_tick) begin
      unique case (state_q)
        CLOSED: begin
          if (ev[7]) begin
            state_d = OPEN;
            focus_d = F_COLORS;
          end
        end
        OPEN: begin
          if (ev[7]) begin
            state_d = CLOSED;
          end else begin
            if (ev[6]) begin
              case (focus_q)
                F_COLORS: focus_d = F_SOUND;
                F_SOUND:  focus_d = F_EXIT;
                default:  focus_d = F_COLORS;
              endcase
            end
            if (focus_q == F_EXIT && ev[4]) state_d = CLOSED;
          end
        end
        default: state_d = CLOSED;
      endcase
    end
  end

  // Pulses go to the component focused before any C advance in the same frame.
  always_comb begin
    colors_en_d  = 1'b0;
    colors_btn_d = 8'h00;
    sound_en_d   = 1'b0;
    sound_btn_d  = 8'h00;
    game_btn_d   = 8'h00;
    menu_exit_d  = 1'b0;
    if (frame_tick) begin
      unique case (state_q)
        CLOSED: begin
          if (!ev[7]) game_btn_d = {1'b0, ev[6:0]};
        end
        OPEN: begin
          if (ev[7]) begin
            menu_exit_d = 1'b1;
          end else begin
            case (focus_q)
              F_COLORS: begin
                if (ev[5:0] != 6'h00) begin
                  colors_en_d  = 1'b1;
                  colors_btn_d = {2'b00, ev[5:0]};
                end
              end
              F_SOUND: begin
                if (ev[5:0] != 6'h00) begin
                  sound_en_d  = 1'b1;
                  sound_btn_d = {2'b00, ev[5:0]};
                end
              end
              default: menu_exit_d = ev[4];
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign menu_open  = (state_q == OPEN);
  assign focus      = focus_q;
  assign colors_en  = colors_en_q;
  assign colors_btn = colors_btn_q;
  assign sound_en   = sound_en_q;
  assign sound_btn  = sound_btn_q;
  assign game_btn   = game_btn_q;
  assign menu_exit  = menu_exit_q;

endmodule
